ex_ctrl: RTL

Execute-stage sequencer for the RV32IM core. It accepts decoded instructions from ID through a valid/ready handshake and issues them to the `ex` datapath. It holds ID during multi-cycle M-extension operations and inserts one bubble on load-use hazards. It produces the writeback strobe and destination for each retired instruction, and aborts in-flight work on flush.

---
 rtl/ex_pkg.sv | 40 ++++
 rtl/ex_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcode map, M-extension marker,
// sequencer state type and operand-usage decode helpers.
package ex_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } ex_state_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

    function automatic logic is_legal(input logic [6:0] opcode);
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_ctrl.sv
// Execute-stage sequencer: ID handshake, multi-cycle M-op hold, one-bubble
// load-use interlock, writeback strobe generation and flush abort.
module ex_ctrl
    import ex_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       flush,
    output logic       ex_fire,
    output logic       ex_busy,
    output logic       wb_valid,
    output logic       wb_we,
    output logic [4:0] wb_rd,
    output logic       illegal
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    ex_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             ld_pend;
    logic [4:0]       ld_rd;
    logic [4:0]       rd_p1;

    logic hazard;
    logic is_mop;
    logic dec_ill;
    logic dec_we;
    logic unused_funct3;

    assign unused_funct3 = ^funct3[1:0];

    always_comb begin
        hazard   = ld_pend && (ld_rd != 5'd0) &&
                   ((uses_rs1(opcode) && (rs1 == ld_rd)) ||
                    (uses_rs2(opcode) && (rs2 == ld_rd)));
        id_ready = (state == IDLE) && !flush && !hazard;
        ex_fire  = id_valid && id_ready;
        is_mop   = (opcode == OP_REG) && (funct7 == FUNCT7_MEXT);
        dec_ill  = !is_legal(opcode);
        dec_we   = !((opcode == OP_STORE) || (opcode == OP_BRANCH) ||
                     (rd == 5'd0) || dec_ill);
    end

    assign ex_busy = (state == MULTI);

    // Issue stage -> M-op destination held until the result retires
    always_ff @(posedge clk) begin
        if (ex_fire && is_mop) begin
            rd_p1 <= rd;
        end
    end

    // Issue stage -> writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ld_pend  <= 1'b0;
            ld_rd    <= 5'd0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            illegal  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            illegal  <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                cnt     <= '0;
                ld_pend <= 1'b0;
            end else begin
                // A stalled cycle drops the pending load so exactly one bubble is inserted
                if (hazard) begin
                    ld_pend <= 1'b0;
                end else if (ex_fire) begin
                    ld_pend <= (opcode == OP_LOAD);
                    if (opcode == OP_LOAD) begin
                        ld_rd <= rd;
                    end
                end

                if (ex_fire) begin
                    if (is_mop) begin
                        state <= MULTI;
                        cnt   <= funct3[2] ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        wb_valid <= 1'b1;
                        wb_we    <= dec_we;
                        wb_rd    <= rd;
                        illegal  <= dec_ill;
                    end
                end else if (state == MULTI) begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_we    <= (rd_p1 != 5'd0);
                        wb_rd    <= rd_p1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
